mem_preload_loader: RTL

MEM_PRELOAD_LOADER -- requirements
Module: mem_preload_loader

---
 rtl/top_pkg.sv | 5 +
 rtl/mem_preload_loader.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/top_pkg.sv
// Shared top-level constants for the memory subsystem.
//   TL_DW : data bus width in bits, used as the default memory word width.
package top_pkg;
    parameter int TL_DW = 32;
endpackage

// File: rtl/mem_preload_loader.sv
// mem_preload_loader
// Streams a preload image into one of NUM_MEM word-addressed memories
// (0 = ICCM, 1 = DCCM by default) before the core is released.
// A command picks the target memory, start address and word count. Data
// words then arrive on a separate handshake, and each one becomes a
// registered single-cycle write. A finish command ends the preload and
// holds preload_finish_o high until reset.
//
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   cmd_valid_i/ready_o    command handshake (sel, addr, len, finish)
//   dat_valid_i/ready_o    data handshake (wdata, bit wmask)
//   mem_we_o               one-hot write strobe, one bit per memory
//   mem_wdata/wmask/waddr  registered write bus, held while mem_we_o = 0
//   preload_finish_o       preload complete
//   err_o                  sticky: a command was rejected
//   words_written_o        saturating count of words written since reset
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a command
// LOAD  | accepting data words until the remaining count reaches zero
// DONE  | preload finished; all handshakes closed until reset
module mem_preload_loader #(
    parameter int DW      = top_pkg::TL_DW,
    parameter int AW      = 11,
    parameter int NUM_MEM = 2,
    parameter int SW      = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [SW-1:0]      cmd_sel_i,
    input  logic [AW-1:0]      cmd_addr_i,
    input  logic [AW:0]        cmd_len_i,
    input  logic               cmd_finish_i,
    input  logic               dat_valid_i,
    output logic               dat_ready_o,
    input  logic [DW-1:0]      dat_wdata_i,
    input  logic [DW-1:0]      dat_wmask_i,
    output logic [NUM_MEM-1:0] mem_we_o,
    output logic [DW-1:0]      mem_wdata_o,
    output logic [DW-1:0]      mem_wmask_o,
    output logic [AW-1:0]      mem_waddr_o,
    output logic               preload_finish_o,
    output logic               err_o,
    output logic [AW+7:0]      words_written_o
);

    localparam int CW = AW + 8;
    localparam logic [AW+1:0] DEPTH_W = {2'b01, {AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      sel_q, sel_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [AW:0]        rem_q, rem_d;
    logic [NUM_MEM-1:0] we_q, we_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [DW-1:0]      wmask_q, wmask_d;
    logic [AW-1:0]      waddr_q, waddr_d;
    logic               err_q, err_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [AW+1:0]      end_addr;
    logic               cmd_bad;
    logic [NUM_MEM-1:0] sel_oh;

    // Two extra bits so addr + len can never wrap before the depth compare.
    assign end_addr = {2'b00, cmd_addr_i} + {1'b0, cmd_len_i};
    assign cmd_bad  = (int'(cmd_sel_i) >= NUM_MEM) || (end_addr > DEPTH_W);

    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < NUM_MEM; i++) begin
            sel_oh[i] = (int'(sel_q) == i);
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        we_d        = '0;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        waddr_d     = waddr_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        cmd_ready_o = 1'b0;
        dat_ready_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Ready is gated by reset so nothing is handshaken while held.
                cmd_ready_o = rst_ni;
                if (cmd_valid_i && rst_ni) begin
                    if (cmd_finish_i) begin
                        state_d = DONE;
                    end else if (cmd_bad) begin
                        err_d = 1'b1;
                    end else if (cmd_len_i != '0) begin
                        sel_d   = cmd_sel_i;
                        addr_d  = cmd_addr_i;
                        rem_d   = cmd_len_i;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                dat_ready_o = rst_ni;
                if (dat_valid_i && rst_ni) begin
                    we_d    = sel_oh;
                    wdata_d = dat_wdata_i;
                    wmask_d = dat_wmask_i;
                    waddr_d = addr_q;
                    addr_d  = addr_q + AW'(1);
                    rem_d   = rem_q - (AW+1)'(1);
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (rem_q == (AW+1)'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            we_q    <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            waddr_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            waddr_q <= waddr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_we_o         = we_q;
    assign mem_wdata_o      = wdata_q;
    assign mem_wmask_o      = wmask_q;
    assign mem_waddr_o      = waddr_q;
    assign preload_finish_o = (state_q == DONE);
    assign err_o            = err_q;
    assign words_written_o  = cnt_q;

endmodule
